rvfi_imem_responder: RTL and testbench

Instruction-fetch responder for formal and simulation harnesses. It answers core fetch requests with data that matches the solver-chosen constant (imem_addr, imem_data) halfword pair used by the instruction-memory consistency check. Every other halfword comes from a free `fill_data` input. It sits between the core's fetch port and the harness, and models a pipelined memory with bounded outstanding requests and a minimum response latency.

---
 rtl/rvfi_imem_responder.sv | 128 ++++++++++++
 tb/tb_rvfi_imem_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_imem_responder.sv
// rvfi_imem_responder
// Instruction-fetch responder for formal/simulation harnesses. Each accepted
// fetch returns two halfwords; the halfword at the solver-chosen imem_addr is
// replaced by imem_data, everything else comes from fill_data. Requests are
// buffered in a small in-order FIFO and each entry is held back until it has
// aged LATENCY cycles, modelling a pipelined memory.

module rvfi_imem_responder #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [XLEN-1:0]            imem_addr,
    input  logic [15:0]                imem_data,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [XLEN-1:0]            req_addr,
    input  logic [31:0]                fill_data,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [31:0]                rsp_data,
    output logic                       rsp_err,
    output logic [$clog2(DEPTH+1)-1:0] outstanding
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW = $clog2(LATENCY + 1);

    logic [31:0]   data_mem [DEPTH];
    logic          err_mem  [DEPTH];
    logic [AW-1:0] age_mem  [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          push;
    logic          pop;
    logic          head_ripe;

    logic [XLEN-1:0] next_addr;
    logic [15:0]     lo_half;
    logic [15:0]     hi_half;
    logic            new_err;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Build the entry for the incoming request from the inputs as they are now
    always_comb begin
        next_addr = req_addr + XLEN'(2);
        lo_half   = fill_data[15:0];
        hi_half   = fill_data[31:16];
        new_err   = 1'b0;
        if (req_addr[0]) begin
            new_err = 1'b1;
            lo_half = 16'h0000;
            hi_half = 16'h0000;
        end else begin
            if (enable && (req_addr == imem_addr)) begin
                lo_half = imem_data;
            end
            if (enable && (next_addr == imem_addr)) begin
                hi_half = imem_data;
            end
        end
    end

    // Handshakes and the visible head of the queue; a pop never frees space for a same-cycle push
    always_comb begin
        req_ready   = reset && (count < CW'(DEPTH));
        head_ripe   = (age_mem[head] >= AW'(LATENCY));
        rsp_valid   = (count != '0) && head_ripe;
        rsp_data    = rsp_valid ? data_mem[head] : 32'h0000_0000;
        rsp_err     = rsp_valid ? err_mem[head] : 1'b0;
        push        = req_valid && req_ready;
        pop         = rsp_valid && rsp_ready;
        outstanding = count;
    end

    // Head/tail pointers and occupancy count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage and per-slot age; empty slots may age freely since a push restarts them at 0
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= 32'h0000_0000;
                err_mem[i]  <= 1'b0;
                age_mem[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (tail == PW'(i))) begin
                    data_mem[i] <= {hi_half, lo_half};
                    err_mem[i]  <= new_err;
                    age_mem[i]  <= '0;
                end else if (age_mem[i] < AW'(LATENCY)) begin
                    age_mem[i]  <= age_mem[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rvfi_imem_responder.sv
// tb_rvfi_imem_responder
// Randomised plus directed stimulus; a queue-based reference model predicts
// occupancy, response timing and response contents of the responder.

module tb_rvfi_imem_responder;

    localparam int XLEN    = 32;
    localparam int DEPTH   = 4;
    localparam int LATENCY = 3;
    localparam int CW      = $clog2(DEPTH + 1);

    logic            clock;
    logic            reset;
    logic            enable;
    logic [XLEN-1:0] imem_addr;
    logic [15:0]     imem_data;
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic [31:0]     fill_data;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_data;
    logic            rsp_err;
    logic [CW-1:0]   outstanding;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] pend_data;
    logic        pend_err;
    int          cyc = 0;
    int          tests = 0;
    int          failures = 0;

    rvfi_imem_responder #(
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .fill_data   (fill_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .outstanding (outstanding)
    );

    // Free-running clock, period 10
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Cycle index: an acceptance at edge n is tagged with cycle n
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference: two halfwords starting at ra, with the checked halfword substituted
    function automatic logic [32:0] ref_entry(input logic en, input logic [31:0] ia, input logic [15:0] id,
                                              input logic [31:0] ra, input logic [31:0] fill);
        logic [31:0] upper_addr;
        logic [15:0] lo;
        logic [15:0] hi;
        if (ra[0]) return {1'b1, 32'h0};
        upper_addr = ra + 32'd2;
        lo = (en && ra == ia) ? id : fill[15:0];
        hi = (en && upper_addr == ia) ? id : fill[31:16];
        return {1'b0, hi, lo};
    endfunction

    // Drive one cycle of inputs just after the rising edge and record what a request should return
    task automatic apply_stimulus(input logic v, input logic [31:0] ra, input logic [31:0] fill,
                                  input logic rr, input logic en, input logic [31:0] ia,
                                  input logic [15:0] id, input logic use_lit, input logic [32:0] lit);
        logic [32:0] e;
        @(posedge clock);
        #1;
        req_valid = v;
        req_addr  = ra;
        fill_data = fill;
        rsp_ready = rr;
        enable    = en;
        imem_addr = ia;
        imem_data = id;
        e = use_lit ? lit : ref_entry(en, ia, id, ra, fill);
        pend_err  = e[32];
        pend_data = e[31:0];
    endtask

    task automatic idle(input int n, input logic rr);
        for (int k = 0; k < n; k++) begin
            apply_stimulus(1'b0, 32'h0, $urandom, rr, enable, imem_addr, imem_data, 1'b0, 33'h0);
        end
    endtask

    // Monitor: mid-cycle, compare the DUT against the model, then advance the model by the pending edge
    always @(negedge clock) begin
        bit   exp_ready;
        bit   exp_valid;
        exp_t ent;
        if (!reset) begin
            check_output("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
            check_output("reset_rsp_data", rsp_data, 32'h0);
            check_output("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
            check_output("reset_req_ready", {31'h0, req_ready}, 32'h0);
            check_output("reset_outstanding", 32'(outstanding), 32'h0);
            sb.delete();
        end else begin
            exp_ready = (sb.size() < DEPTH);
            exp_valid = (sb.size() > 0) && (cyc >= sb[0].acc + LATENCY);
            check_output("req_ready", {31'h0, req_ready}, {31'h0, exp_ready});
            check_output("outstanding", 32'(outstanding), 32'(sb.size()));
            check_output("rsp_valid", {31'h0, rsp_valid}, {31'h0, exp_valid});
            if (exp_valid && rsp_valid) begin
                check_output("rsp_data", rsp_data, sb[0].data);
                check_output("rsp_err", {31'h0, rsp_err}, {31'h0, sb[0].err});
            end else if (!rsp_valid) begin
                check_output("idle_rsp_data", rsp_data, 32'h0);
                check_output("idle_rsp_err", {31'h0, rsp_err}, 32'h0);
            end
            if (exp_valid && rsp_ready) void'(sb.pop_front());
            if (req_valid && exp_ready) begin
                ent.data = pend_data;
                ent.err  = pend_err;
                ent.acc  = cyc + 1;
                sb.push_back(ent);
            end
        end
    end

    initial begin
        logic [31:0] ia;
        logic [31:0] ra;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        fill_data = '0;
        rsp_ready = 1'b1;
        enable    = 1'b1;
        imem_addr = 32'h100;
        imem_data = 16'hA5A5;
        pend_data = '0;
        pend_err  = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        $display("[TB] reset released");

        // Directed: low-half match, high-half match across address wrap, enable off, misaligned
        apply_stimulus(1'b1, 32'h100, 32'h12345678, 1'b1, 1'b1, 32'h100, 16'hA5A5, 1'b1, {1'b0, 32'h1234A5A5});
        apply_stimulus(1'b1, 32'hFFFFFFFE, 32'hDEADBEEF, 1'b1, 1'b1, 32'h0, 16'hA5A5, 1'b1, {1'b0, 32'hA5A5BEEF});
        apply_stimulus(1'b1, 32'hFFFFFFFE, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 16'hA5A5, 1'b1, {1'b0, 32'hDEADBEEF});
        apply_stimulus(1'b1, 32'h101, 32'hCAFEF00D, 1'b1, 1'b1, 32'h100, 16'hA5A5, 1'b1, {1'b1, 32'h0});
        idle(8, 1'b1);

        // Backpressure: fill the queue, hold the consumer off, then drain
        for (int k = 0; k < 6; k++) begin
            apply_stimulus(1'b1, 32'h100 + 32'(2 * k), $urandom, 1'b0, 1'b1, 32'h104, 16'h5A5A, 1'b0, 33'h0);
        end
        idle(4, 1'b0);
        idle(8, 1'b1);

        // Streaming: simultaneous push and pop
        for (int k = 0; k < 20; k++) begin
            apply_stimulus(1'b1, 32'h200 + 32'(2 * k), $urandom, 1'b1, 1'b1, 32'h210, 16'h1111, 1'b0, 33'h0);
        end
        idle(6, 1'b1);

        // Reset with entries in flight
        apply_stimulus(1'b1, 32'h300, $urandom, 1'b0, 1'b1, 32'h300, 16'h7777, 1'b0, 33'h0);
        apply_stimulus(1'b1, 32'h302, $urandom, 1'b0, 1'b1, 32'h300, 16'h7777, 1'b0, 33'h0);
        idle(4, 1'b0);
        @(posedge clock);
        #2;
        req_valid = 1'b0;
        reset     = 1'b0;
        #1;
        check_output("async_reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check_output("async_reset_outstanding", 32'(outstanding), 32'h0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        idle(6, 1'b1);

        // Random traffic around a handful of checked addresses
        ia = 32'h1000;
        for (int k = 0; k < 1500; k++) begin
            if (k % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0:       ia = 32'h0;
                    1:       ia = 32'hFFFFFFFE;
                    default: ia = {$urandom} & 32'hFFFF_FFFE;
                endcase
            end
            case ($urandom_range(0, 6))
                0:       ra = ia;
                1:       ra = ia - 32'd2;
                2:       ra = ia + 32'd2;
                3:       ra = ia + 32'd1;
                4:       ra = ia - 32'd4;
                5:       ra = $urandom;
                default: ra = {$urandom} & 32'hFFFF_FFFE;
            endcase
            apply_stimulus($urandom_range(0, 3) != 0, ra, $urandom, $urandom_range(0, 9) < 7,
                           $urandom_range(0, 4) != 0, ia, 16'($urandom), 1'b0, 33'h0);
        end

        // Drain with a bounded wait
        begin
            int budget;
            budget = 0;
            while (sb.size() > 0 && budget < 200) begin
                idle(1, 1'b1);
                budget++;
            end
            check_output("drain_queue_empty", 32'(sb.size()), 32'h0);
        end
        idle(2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
